// File: rtl/alu_slice_exec.sv
// Multi-cycle 32-bit ALU that executes one operation as four sequential 8-bit slices.
// An accepted operation completes four edges later with a one-cycle done pulse.
module alu_slice_exec (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  alu_ctr,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        zero,
  output logic        ovf,
  output logic        illegal
);

  typedef enum logic {S_IDLE, S_EXEC} state_e;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_SLT = 3'b100,
    OP_ADD = 3'b101,
    OP_SUB = 3'b110
  } op_e;

  state_e      r_state;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [2:0]  r_op;
  logic [1:0]  r_k;
  logic        r_carry;
  logic [23:0] r_acc;
  logic        r_busy;
  logic        r_done;
  logic [31:0] r_result;
  logic        r_zero;
  logic        r_ovf;
  logic        r_illegal;

  logic [7:0]  w_sa;
  logic [7:0]  w_sb_raw;
  logic [7:0]  w_sb;
  logic [8:0]  w_add9;
  logic        w_arith;
  logic        w_inv;
  logic        w_legal;
  logic [7:0]  w_slice;
  logic        w_ovf_int;
  logic [31:0] w_full;
  logic [31:0] w_final;
  logic        w_final_ovf;
  logic        w_accept_inv;

  assign w_sa     = r_a[{r_k, 3'b000} +: 8];
  assign w_sb_raw = r_b[{r_k, 3'b000} +: 8];

  always_comb begin
    w_arith = 1'b0;
    w_inv   = 1'b0;
    w_legal = 1'b1;
    case (r_op)
      OP_AND, OP_OR:  w_arith = 1'b0;
      OP_ADD:         w_arith = 1'b1;
      OP_SUB, OP_SLT: begin
        w_arith = 1'b1;
        w_inv   = 1'b1;
      end
      default:        w_legal = 1'b0;
    endcase
  end

  assign w_sb   = w_inv ? ~w_sb_raw : w_sb_raw;
  assign w_add9 = {1'b0, w_sa} + {1'b0, w_sb} + {8'b0, r_carry};

  always_comb begin
    w_slice = '0;
    case (r_op)
      OP_AND:                 w_slice = w_sa & w_sb_raw;
      OP_OR:                  w_slice = w_sa | w_sb_raw;
      OP_ADD, OP_SUB, OP_SLT: w_slice = w_add9[7:0];
      default:                w_slice = '0;
    endcase
  end

  // Only meaningful on the top slice: carry into bit 31 is recovered from the
  // sum bit, then compared against the slice carry-out.
  assign w_ovf_int = (w_sa[7] ^ w_sb[7] ^ w_add9[7]) ^ w_add9[8];
  assign w_full    = {w_slice, r_acc};

  always_comb begin
    w_final     = '0;
    w_final_ovf = 1'b0;
    case (r_op)
      OP_AND, OP_OR: w_final = w_full;
      OP_ADD, OP_SUB: begin
        w_final     = w_full;
        w_final_ovf = w_ovf_int;
      end
      OP_SLT:        w_final = {31'b0, w_add9[7] ^ w_ovf_int};
      default:       w_final = '0;
    endcase
  end

  assign w_accept_inv = (alu_ctr == OP_SUB) || (alu_ctr == OP_SLT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_op      <= '0;
      r_k       <= '0;
      r_carry   <= 1'b0;
      r_acc     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_result  <= '0;
      r_zero    <= 1'b1;
      r_ovf     <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_op    <= alu_ctr;
            r_k     <= '0;
            r_carry <= w_accept_inv;
            r_busy  <= 1'b1;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (w_arith) begin
            r_carry <= w_add9[8];
          end
          case (r_k)
            2'd0: r_acc[7:0]   <= w_slice;
            2'd1: r_acc[15:8]  <= w_slice;
            2'd2: r_acc[23:16] <= w_slice;
            default: ;
          endcase
          if (r_k == 2'd3) begin
            // Counter parks at 3; only the next accept returns it to 0.
            r_result  <= w_final;
            r_zero    <= (w_final == '0);
            r_ovf     <= w_final_ovf;
            r_illegal <= ~w_legal;
            r_done    <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= S_IDLE;
          end else begin
            r_k <= r_k + 2'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign result  = r_result;
  assign zero    = r_zero;
  assign ovf     = r_ovf;
  assign illegal = r_illegal;

endmodule

// File: tb/tb_alu_slice_exec.sv
// Directed self-checking bench for alu_slice_exec: hand-computed vectors,
// latency/busy timing, back-to-back accept, start-while-busy and mid-op reset.
module tb_alu_slice_exec;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  alu_ctr;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        zero;
  logic        ovf;
  logic        illegal;

  int unsigned n_tests;
  int unsigned n_fail;
  logic [31:0] prev_result;
  int unsigned cyc;
  int unsigned busy_cnt;
  int unsigned done_cnt;

  alu_slice_exec dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .alu_ctr (alu_ctr),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .zero    (zero),
    .ovf     (ovf),
    .illegal (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"},    {31'b0, busy},    32'd0);
    check({tag, "_done"},    {31'b0, done},    32'd0);
    check({tag, "_result"},  result,           32'd0);
    check({tag, "_zero"},    {31'b0, zero},    32'd1);
    check({tag, "_ovf"},     {31'b0, ovf},     32'd0);
    check({tag, "_illegal"}, {31'b0, illegal}, 32'd0);
  endtask

  // Issue one op from idle, check busy/done timing, then the registered outputs.
  task automatic run_op(input string tag, input logic [2:0] ctr, input logic [31:0] va,
                        input logic [31:0] vb, input logic [31:0] exp_res,
                        input logic exp_zero, input logic exp_ovf, input logic exp_ill);
    @(negedge clk);
    start   = 1'b1;
    alu_ctr = ctr;
    a       = va;
    b       = vb;
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    a        = ~va;
    b        = ~vb;
    busy_cnt = 0;
    if (busy) busy_cnt++;
    check({tag, "_hold_at_accept"}, result, prev_result);
    cyc = 0;
    while (!done && cyc < 10) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (busy) busy_cnt++;
      if (!done) check({tag, "_hold_in_exec"}, result, prev_result);
    end
    check({tag, "_latency"}, cyc, 32'd4);
    check({tag, "_busy_cycles"}, busy_cnt, 32'd4);
    check({tag, "_result"},  result,           exp_res);
    check({tag, "_zero"},    {31'b0, zero},    {31'b0, exp_zero});
    check({tag, "_ovf"},     {31'b0, ovf},     {31'b0, exp_ovf});
    check({tag, "_illegal"}, {31'b0, illegal}, {31'b0, exp_ill});
    prev_result = exp_res;
    @(negedge clk);
    check({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
    check({tag, "_hold_after"}, result, exp_res);
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    prev_result = 32'd0;
    rst_n       = 1'b0;
    start       = 1'b0;
    alu_ctr     = 3'b000;
    a           = 32'd0;
    b           = 32'd0;

    #12;
    check_reset_vals("por");
    @(negedge clk);
    rst_n = 1'b1;

    run_op("add_ovf",  3'b101, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0);
    run_op("sub_eq",   3'b110, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1'b0);
    run_op("sub_ovf",  3'b110, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0);
    run_op("slt_neg",  3'b100, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0);
    run_op("slt_pos",  3'b100, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b0);
    run_op("slt_min",  3'b100, 32'h80000000, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0);
    run_op("and",      3'b000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1'b0);
    run_op("or",       3'b001, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 1'b0, 1'b0);
    run_op("ill_010",  3'b010, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b1, 1'b0, 1'b1);
    run_op("add_mix",  3'b101, 32'h00FF00FF, 32'h00010001, 32'h01000100, 1'b0, 1'b0, 1'b0);
    run_op("ill_011",  3'b011, 32'h00000001, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b1);
    run_op("sub_neg",  3'b110, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
    run_op("ill_111",  3'b111, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b1);

    // start held high with changing operands; a new op is accepted in the done cycle
    @(negedge clk);
    start   = 1'b1;
    alu_ctr = 3'b000;
    a       = 32'hF0F0F0F0;
    b       = 32'hFF00FF00;
    @(posedge clk);
    cyc = 0;
    @(negedge clk);
    while (!done && cyc < 10) begin
      alu_ctr = 3'b001;
      a       = 32'h0F0F0F0F + cyc;
      b       = 32'h11111111 * (cyc + 1);
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    check("hold_start_latency", cyc, 32'd4);
    check("hold_start_result", result, 32'hF000F000);
    alu_ctr = 3'b101;
    a       = 32'd1;
    b       = 32'd2;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy", {31'b0, busy}, 32'd1);
    check("b2b_done_low", {31'b0, done}, 32'd0);
    cyc = 0;
    while (!done && cyc < 10) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    check("b2b_latency", cyc, 32'd4);
    check("b2b_result", result, 32'd3);
    prev_result = 32'd3;

    // reset after E2 of an ADD aborts it
    @(negedge clk);
    start   = 1'b1;
    alu_ctr = 3'b101;
    a       = 32'h7FFFFFFF;
    b       = 32'h00000001;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_vals("rst_mid");
    @(negedge clk);
    @(negedge clk);
    rst_n    = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("rst_no_done", done_cnt, 32'd0);
    check("rst_busy_idle", {31'b0, busy}, 32'd0);
    prev_result = 32'd0;
    run_op("post_rst", 3'b101, 32'h00000010, 32'h00000020, 32'h00000030, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_slice_exec.md
ALU_SLICE_EXEC -- requirements
Module: alu_slice_exec

Interface
REQ-001 No parameters; datapath width fixed at 32 bits, processed as four 8-bit slices.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request to execute one operation; sampled only when busy=0.
REQ-005 alu_ctr  input  3  operation code: 000 AND, 001 OR, 100 SLT, 101 ADD, 110 SUB; 010/011/111 illegal.
REQ-006 a  input  32  operand A (signed for SLT/overflow).
REQ-007 b  input  32  operand B.
REQ-008 busy  output  1  high while an operation is in progress.
REQ-009 done  output  1  single-cycle completion pulse.
REQ-010 result  output  32  registered result of last completed operation.
REQ-011 zero  output  1  high when result == 0.
REQ-012 ovf  output  1  signed overflow of last ADD/SUB; 0 for all other codes.
REQ-013 illegal  output  1  high with done when the completed operation used an illegal code.

Function
REQ-014 FSM states: IDLE, EXEC; busy=1 exactly in EXEC.
REQ-015 Accept: rising edge with busy=0 and start=1 latches a, b, alu_ctr, clears slice counter to 0, moves to EXEC.
REQ-016 On accept, carry register loads 1 for SUB/SLT (B inverted), 0 otherwise.
REQ-017 Each EXEC edge processes slice k (bits 8k+7:8k) for k=0..3, writes it into an internal accumulator, updates carry, increments k.
REQ-018 ADD/SUB/SLT slices use 8-bit add of A slice, (B or ~B) slice, carry-in; AND/OR slices are bitwise.
REQ-019 Latency: accept at edge E0; slices at E1..E4; at E4 result, zero, ovf, illegal update, done=1, busy=0, state returns to IDLE.
REQ-020 done is high only for the cycle following E4.
REQ-021 ovf = carry into bit 31 XOR carry out of bit 31, computed at E4 for ADD/SUB.
REQ-022 SLT result = {31'b0, sum[31] XOR ovf_internal}; ovf output stays 0 for SLT.
REQ-023 Illegal codes: still take 4 EXEC cycles; result=0, zero=1, ovf=0, illegal=1 at E4.
REQ-024 start while busy=1 ignored, not queued; a, b, alu_ctr changes during EXEC have no effect.
REQ-025 start=1 in the done cycle (busy=0) is accepted; sustained throughput one operation per 4 cycles.
REQ-026 result, zero, ovf, illegal hold until next completion; they do not change at accept or during EXEC.
REQ-027 Slice counter wraps from 3 to 0 only via accept; no other path modifies it.

Reset
REQ-028 rst_n=0 forces immediately: state IDLE, busy=0, done=0, result=0, zero=1, ovf=0, illegal=0, counter=0, carry=0.
REQ-029 Reset asserted mid-EXEC aborts the operation; no done is produced for it after rst_n deasserts.
REQ-030 First accept possible on the first rising edge with rst_n=1.

Verification
REQ-031 ADD a=0x7FFFFFFF b=0x00000001 -> result 0x80000000, ovf=1, zero=0, done exactly 4 cycles after accept edge, busy high 4 cycles.
REQ-032 SUB a=5 b=5 -> result 0, zero=1, ovf=0; SUB a=0x80000000 b=1 -> 0x7FFFFFFF, ovf=1.
REQ-033 SLT a=0xFFFFFFFF b=1 -> 1; a=1 b=0xFFFFFFFF -> 0; a=0x80000000 b=1 -> 1, ovf=0.
REQ-034 AND 0xF0F0F0F0,0xFF00FF00 -> 0xF000F000; OR same operands -> 0xFFF0FFF0; code 010 -> result 0, zero=1, illegal=1.
REQ-035 start held high with changing operands during EXEC -> only first op executes; start in done cycle -> second op accepted, done 4 cycles later.
REQ-036 rst_n low after E2 of an ADD -> outputs at reset values immediately, no done pulse after release; next start completes normally.
